sid_multi_regs: RTL and testbench

SID_MULTI_REGS -- requirements
Module: sid_multi_regs

---
 rtl/sid_pkg.sv | 64 ++++++
 rtl/sid_multi_regs_magic_cfg.sv | 60 ++++++
 rtl/sid_multi_regs.sv | 111 +++++++++++
 tb/tb_sid_multi_regs.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared types and constants for the multi-SID register front end.
package sid;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
    logic       we;
    logic       oe;
    logic       res;
  } bus_i_t;

  // Read-only bytes 0x19..0x1C: potx, poty, osc3, env3
  typedef struct packed {
    logic [3:0][7:0] bytes;
  } reg_o_t;

  typedef struct packed {
    logic [31:0][7:0] bytes;
  } reg_i_t;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } sid_model_e;

  typedef enum logic [1:0] {
    ADDR_D400 = 2'd0,
    ADDR_D420 = 2'd1,
    ADDR_D500 = 2'd2,
    ADDR_DE00 = 2'd3
  } sid_addr_e;

  typedef struct packed {
    sid_model_e model;
    sid_addr_e  addr;
    logic [7:0] fc_base;
    logic [7:0] fc_offset;
  } cfg_t;

  typedef enum logic [1:0] {
    MAGIC_IDLE     = 2'd0,
    MAGIC_KEY1     = 2'd1,
    MAGIC_UNLOCKED = 2'd2
  } magic_state_e;

  localparam logic [7:0] SID_MAGIC_KEY1     = 8'h52;
  localparam logic [7:0] SID_MAGIC_KEY2     = 8'h44;
  localparam logic [4:0] SID_MAGIC_CMD_ADDR = 5'h1F;
  localparam logic [4:0] SID_MAGIC_KEY_ADDR = 5'h1E;
  localparam logic [4:0] SID_RO_FIRST       = 5'h19;
  localparam logic [4:0] SID_RO_LAST        = 5'h1C;

  localparam cfg_t SID_CFG_RESET = '{
    model:     MOS6581,
    addr:      ADDR_D420,
    fc_base:   8'h00,
    fc_offset: 8'h00
  };

  function automatic logic is_ro_addr(input logic [4:0] a);
    return (a >= SID_RO_FIRST) && (a <= SID_RO_LAST);
  endfunction

endpackage

// File: rtl/sid_multi_regs_magic_cfg.sv
// Per-SID magic-key unlock sequence that updates the SID configuration.
module sid_magic_cfg
  import sid::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_res,
  input  logic       wr_en,
  input  logic [4:0] addr,
  input  logic [7:0] data,
  output cfg_t       cfg
);

  magic_state_e state_reg, state_next;
  cfg_t         cfg_reg, cfg_next;

  always_comb begin
    state_next = state_reg;
    cfg_next   = cfg_reg;
    if (wr_en) begin
      case (state_reg)
        MAGIC_IDLE: begin
          if (addr == SID_MAGIC_KEY_ADDR && data == SID_MAGIC_KEY1)
            state_next = MAGIC_KEY1;
        end
        MAGIC_KEY1: begin
          // Any write other than the second key breaks the sequence
          state_next = (addr == SID_MAGIC_KEY_ADDR && data == SID_MAGIC_KEY2)
                       ? MAGIC_UNLOCKED : MAGIC_IDLE;
        end
        MAGIC_UNLOCKED: begin
          if (addr == SID_MAGIC_CMD_ADDR) begin
            state_next = MAGIC_IDLE;
            case (data[7:6])
              2'b00:   cfg_next.model = sid_model_e'(data[0]);
              2'b01:   cfg_next.addr  = sid_addr_e'(data[1:0]);
              default: ;
            endcase
          end
        end
        default: state_next = MAGIC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MAGIC_IDLE;
      cfg_reg   <= SID_CFG_RESET;
    end else if (bus_res) begin
      state_reg <= MAGIC_IDLE;
    end else begin
      state_reg <= state_next;
      cfg_reg   <= cfg_next;
    end
  end

  assign cfg = cfg_reg;

endmodule

// File: rtl/sid_multi_regs.sv
// Multi-SID register file with floating-bus latch and magic config unlock.
// Optional build macro SID_BUS_DECAY_EN adds the bus latch decay counter.
module sid_multi_regs
  import sid::*;
#(
  parameter int N_SID       = 2,
  parameter int DECAY_TICKS = 2000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   phi2,
  input  bus_i_t                 bus_i,
  input  logic [N_SID-1:0]       cs,
  input  reg_o_t [N_SID-1:0]     reg_o,
  output reg_i_t [N_SID-1:0]     reg_i,
  output cfg_t   [N_SID-1:0]     cfg,
  output logic   [7:0]           data_o
);

  logic       bus_res;
  logic       wr_any;
  logic       rd_any;
  logic       rd_is_ro;
  logic [4:0] ro_off;
  logic [7:0] rd_ro_byte;
  logic [7:0] rd_data;
  logic [7:0] latch_reg;
  logic [7:0] data_o_reg;
  logic       decay_expire;
  reg_i_t     reg_i_reg [N_SID];

  // Bus reset wins over any access in the same tick; a write wins over a read
  assign bus_res  = phi2 & bus_i.res;
  assign wr_any   = phi2 & ~bus_i.res & bus_i.we & (|cs);
  assign rd_any   = phi2 & ~bus_i.res & bus_i.oe & ~bus_i.we & (|cs);
  assign rd_is_ro = is_ro_addr(bus_i.addr);
  assign ro_off   = bus_i.addr - SID_RO_FIRST;

  always_comb begin
    rd_ro_byte = 8'h00;
    for (int k = N_SID - 1; k >= 0; k--) begin
      if (cs[k]) rd_ro_byte = reg_o[k].bytes[ro_off[1:0]];
    end
  end

  assign rd_data = rd_is_ro ? rd_ro_byte : latch_reg;

`ifdef SID_BUS_DECAY_EN
  localparam int CW = $clog2(DECAY_TICKS + 1);
  logic [CW-1:0] decay_reg;

  always_ff @(posedge clk) begin
    if (rst || bus_res) begin
      decay_reg <= '0;
    end else if (wr_any || rd_any) begin
      decay_reg <= CW'(DECAY_TICKS);
    end else if (phi2 && decay_reg != '0) begin
      decay_reg <= decay_reg - 1'b1;
    end
  end

  assign decay_expire = phi2 & ~bus_res & ~wr_any & ~rd_any & (decay_reg == CW'(1));
`else
  assign decay_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || bus_res) begin
      latch_reg <= 8'h00;
    end else if (wr_any) begin
      latch_reg <= bus_i.data;
    end else if (rd_any && rd_is_ro) begin
      latch_reg <= rd_ro_byte;
    end else if (decay_expire) begin
      latch_reg <= 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o_reg <= 8'h00;
    end else if (rd_any) begin
      data_o_reg <= rd_data;
    end
  end

  assign data_o = data_o_reg;

  for (genvar gi = 0; gi < N_SID; gi++) begin : g_sid
    always_ff @(posedge clk) begin
      if (rst || bus_res) begin
        reg_i_reg[gi] <= '0;
      end else if (wr_any && cs[gi]) begin
        reg_i_reg[gi].bytes[bus_i.addr] <= bus_i.data;
      end
    end

    assign reg_i[gi] = reg_i_reg[gi];

    sid_magic_cfg u_magic (
      .clk     (clk),
      .rst     (rst),
      .bus_res (bus_res),
      .wr_en   (wr_any & cs[gi]),
      .addr    (bus_i.addr),
      .data    (bus_i.data),
      .cfg     (cfg[gi])
    );
  end

endmodule

// File: tb/tb_sid_multi_regs.sv
// Directed bench for sid_multi_regs (N_SID=2, DECAY_TICKS=4).
module tb_sid_multi_regs;
  import sid::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             phi2;
  bus_i_t           bus_i;
  logic   [1:0]     cs;
  reg_o_t [1:0]     reg_o;
  reg_i_t [1:0]     reg_i;
  cfg_t   [1:0]     cfg;
  logic   [7:0]     data_o;

  int n_checks = 0;
  int n_errors = 0;

  sid_multi_regs #(.N_SID(2), .DECAY_TICKS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .phi2   (phi2),
    .bus_i  (bus_i),
    .cs     (cs),
    .reg_o  (reg_o),
    .reg_i  (reg_i),
    .cfg    (cfg),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic access(input logic [1:0] sel, input logic [4:0] a, input logic [7:0] d,
                        input logic w, input logic o, input logic r);
    @(negedge clk);
    cs         = sel;
    bus_i.addr = a;
    bus_i.data = d;
    bus_i.we   = w;
    bus_i.oe   = o;
    bus_i.res  = r;
    phi2       = 1'b1;
    @(negedge clk);
    phi2  = 1'b0;
    cs    = 2'b00;
    bus_i = '0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [4:0] a, input logic [7:0] d);
    access(sel, a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [4:0] a);
    access(sel, a, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(2'b00, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic unlock(input logic [1:0] sel);
    wr(sel, 5'h1E, 8'h52);
    wr(sel, 5'h1E, 8'h44);
  endtask

  initial begin
    rst   = 1'b1;
    phi2  = 1'b0;
    cs    = 2'b00;
    bus_i = '0;
    reg_o = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_data_o", 32'(data_o), 32'h00);
    check("rst_reg_i0_nz", 32'(|reg_i[0]), 32'h0);
    check("rst_cfg0_model", 32'(cfg[0].model), 32'h0);
    check("rst_cfg0_addr", 32'(cfg[0].addr), 32'h1);
    check("rst_cfg1_addr", 32'(cfg[1].addr), 32'h1);

    // Single-SID write
    wr(2'b01, 5'h00, 8'hAB);
    check("wr_sid0_b0", 32'(reg_i[0].bytes[0]), 32'hAB);
    check("wr_sid1_b0", 32'(reg_i[1].bytes[0]), 32'h00);

    // Magic unlock: model command on SID0
    unlock(2'b01);
    wr(2'b01, 5'h1F, 8'h01);
    check("magic_model0", 32'(cfg[0].model), 32'h1);
    check("magic_model1_untouched", 32'(cfg[1].model), 32'h0);
    wr(2'b01, 5'h1F, 8'h01);
    wr(2'b01, 5'h1F, 8'h00);
    check("nokey_model0", 32'(cfg[0].model), 32'h1);
    check("nokey_stored", 32'(reg_i[0].bytes[31]), 32'h00);

    // Address command and ignored 1x command on SID1
    unlock(2'b10);
    wr(2'b10, 5'h1F, 8'h43);
    check("magic_addr1", 32'(cfg[1].addr), 32'h3);
    check("magic_addr0_untouched", 32'(cfg[0].addr), 32'h1);
    unlock(2'b10);
    wr(2'b10, 5'h1F, 8'h81);
    check("cmd1x_model1", 32'(cfg[1].model), 32'h0);
    check("cmd1x_addr1", 32'(cfg[1].addr), 32'h3);

    // Interrupted key sequence
    wr(2'b10, 5'h1E, 8'h52);
    wr(2'b10, 5'h05, 8'h10);
    wr(2'b10, 5'h1E, 8'h44);
    wr(2'b10, 5'h1F, 8'h01);
    check("broken_key_model1", 32'(cfg[1].model), 32'h0);
    check("broken_key_stored", 32'(reg_i[1].bytes[5]), 32'h10);

    // Unlocked state survives writes to other addresses
    unlock(2'b10);
    wr(2'b10, 5'h03, 8'h55);
    wr(2'b10, 5'h1F, 8'h01);
    check("unlocked_hold_model1", 32'(cfg[1].model), 32'h1);

    // Bus latch readback and decay
    wr(2'b01, 5'h00, 8'h77);
    rd(2'b01, 5'h00);
    check("latch_read", 32'(data_o), 32'h77);
    idle(3);
    rd(2'b01, 5'h00);
    check("latch_3ticks", 32'(data_o), 32'h77);
    idle(4);
    rd(2'b01, 5'h00);
`ifdef SID_BUS_DECAY_EN
    check("latch_4ticks", 32'(data_o), 32'h00);
`else
    check("latch_4ticks", 32'(data_o), 32'h77);
`endif

    // Read-only bytes, lowest-index select, write-over-read
    reg_o[0].bytes[2] = 8'h12;
    reg_o[1].bytes[2] = 8'h34;
    rd(2'b11, 5'h1B);
    check("ro_cs11", 32'(data_o), 32'h12);
    rd(2'b10, 5'h1B);
    check("ro_cs10", 32'(data_o), 32'h34);
    rd(2'b01, 5'h05);
    check("latch_from_ro", 32'(data_o), 32'h34);
    access(2'b11, 5'h1B, 8'h99, 1'b1, 1'b1, 1'b0);
    check("weoe_data_o", 32'(data_o), 32'h34);
    check("weoe_sid0", 32'(reg_i[0].bytes[27]), 32'h99);
    check("weoe_sid1", 32'(reg_i[1].bytes[27]), 32'h99);

    // Bus reset clears registers and latch but keeps cfg
    access(2'b00, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("res_reg_i0_nz", 32'(|reg_i[0]), 32'h0);
    check("res_reg_i1_nz", 32'(|reg_i[1]), 32'h0);
    check("res_cfg0_model", 32'(cfg[0].model), 32'h1);
    check("res_cfg1_addr", 32'(cfg[1].addr), 32'h3);
    rd(2'b01, 5'h05);
    check("res_latch", 32'(data_o), 32'h00);

    // Hard reset mid-sequence
    wr(2'b01, 5'h1E, 8'h52);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hrst_cfg0_model", 32'(cfg[0].model), 32'h0);
    check("hrst_cfg1_addr", 32'(cfg[1].addr), 32'h1);
    wr(2'b01, 5'h1E, 8'h44);
    wr(2'b01, 5'h1F, 8'h01);
    check("hrst_abort_model0", 32'(cfg[0].model), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
